// File: rtl/debounce_bank.sv
// debounce_bank: per-channel input synchroniser, settle filter, edge pulses and optional auto-repeat.
module debounce_bank #(
    parameter int                  CHANNELS      = 8,
    parameter int                  CLK_FREQ      = 100,
    parameter int                  JITTER_MAX    = 10000,
    parameter logic [CHANNELS-1:0] INIT_VALUE    = '0,
    parameter logic [CHANNELS-1:0] REPEAT_MASK   = '0,
    parameter int                  REPEAT_DELAY  = 500000,
    parameter int                  REPEAT_PERIOD = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] sig_i,
    output logic [CHANNELS-1:0] sig_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
    output logic [CHANNELS-1:0] press_o
);
    localparam int CLK_COUNT  = CLK_FREQ * JITTER_MAX;
    localparam int DELAY_CYC  = CLK_FREQ * REPEAT_DELAY;
    localparam int PERIOD_CYC = CLK_FREQ * REPEAT_PERIOD;
    localparam int CW         = $clog2(CLK_COUNT);
    localparam int HW_RAW     = $clog2(DELAY_CYC) > $clog2(PERIOD_CYC) ? $clog2(DELAY_CYC) : $clog2(PERIOD_CYC);
    localparam int HW         = HW_RAW < 1 ? 1 : HW_RAW;
    genvar n;
    generate
        for (n = 0; n < CHANNELS; n++) begin : g_ch
            logic          s0, s1, st, rise, fall, rep, rph;
            logic [CW-1:0] cnt;
            logic [HW-1:0] hcnt;
            logic          settle_done, flip;
            assign settle_done = cnt == CW'(CLK_COUNT - 1);
            assign flip        = (s1 != st) && settle_done;
            always_ff @(posedge clk) begin
                if (rst) begin
                    s0   <= INIT_VALUE[n];
                    s1   <= INIT_VALUE[n];
                    st   <= INIT_VALUE[n];
                    cnt  <= '0;
                    rise <= 1'b0;
                    fall <= 1'b0;
                    hcnt <= '0;
                    rph  <= 1'b0;
                    rep  <= 1'b0;
                end else begin
                    s0   <= sig_i[n];
                    s1   <= s0;
                    rise <= flip && s1;
                    fall <= flip && !s1;
                    cnt  <= (s1 == st || settle_done) ? '0 : cnt + CW'(1);
                    if (flip)
                        st <= s1;
                    // a falling edge also swallows any repeat due on that same edge
                    if (!REPEAT_MASK[n] || !st || flip) begin
                        hcnt <= '0;
                        rph  <= 1'b0;
                        rep  <= 1'b0;
                    end else if (hcnt == (rph ? HW'(PERIOD_CYC - 1) : HW'(DELAY_CYC - 1))) begin
                        hcnt <= '0;
                        rph  <= 1'b1;
                        rep  <= 1'b1;
                    end else begin
                        hcnt <= hcnt + HW'(1);
                        rep  <= 1'b0;
                    end
                end
            end
            assign sig_o[n]   = st;
            assign rise_o[n]  = rise;
            assign fall_o[n]  = fall;
            assign press_o[n] = rise | rep;
        end
    endgenerate
endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel debouncer for the board's buttons and switches, with per-channel edge pulses and optional auto-repeat. It sits between the raw pad inputs and the CPU/display control logic. It replaces ad-hoc single-signal debouncers with one block serving a whole bank. Every input is synchronised, filtered independently, and reported both as a clean level and as one-cycle event pulses.

## Interface
- CHANNELS, 8: number of independent input channels (1..32).
- CLK_FREQ, 100: main clock frequency in MHz.
- JITTER_MAX, 10000: settle time in us; CLK_COUNT = CLK_FREQ*JITTER_MAX cycles (must be ≥ 2).
- INIT_VALUE, 0: CHANNELS-wide reset/initial level of each channel.
- REPEAT_MASK, 0: CHANNELS-wide; bit n = 1 enables auto-repeat on channel n.
- REPEAT_DELAY, 500000: us from press to first repeat; DELAY_CYC = CLK_FREQ*REPEAT_DELAY (≥ 1).
- REPEAT_PERIOD, 100000: us between repeats; PERIOD_CYC = CLK_FREQ*REPEAT_PERIOD (≥ 1).

- clk  in  1  main clock; everything on posedge.
- rst  in  1  synchronous reset, active-high.
- sig_i  in  CHANNELS  raw asynchronous inputs with jitter.
- sig_o  out  CHANNELS  debounced levels.
- rise_o  out  CHANNELS  one-cycle pulse per debounced 0→1.
- fall_o  out  CHANNELS  one-cycle pulse per debounced 1→0.
- press_o  out  CHANNELS  rise_o OR auto-repeat pulse.

## Operation
- Per channel: 2-flop synchroniser (s0, s1), settle counter cnt, stable register (drives sig_o), hold counter hcnt, repeat-phase flag rph.
- Settle filter, evaluated each edge in priority order:
  - rst: all state cleared.
  - s1 == sig_o: cnt ← 0.
  - cnt == CLK_COUNT-1: cnt ← 0, sig_o ← s1.
  - else: cnt ← cnt+1.
- A glitch shorter than CLK_COUNT cycles at s1 resets cnt and never reaches sig_o.
- rise_o/fall_o are registered. They are high exactly for the cycle after the edge at which sig_o changes, i.e. coincident with the new sig_o value's first cycle.
- Auto-repeat, only on channels with REPEAT_MASK=1 (other channels: hcnt, rph held 0, press_o = rise_o):
  - On the edge where sig_o goes 0→1: hcnt ← 0, rph ← 0.
  - While sig_o = 1 and rph = 0: hcnt increments. When hcnt == DELAY_CYC-1, emit a repeat pulse, hcnt ← 0, rph ← 1.
  - While sig_o = 1 and rph = 1: when hcnt == PERIOD_CYC-1, emit a pulse and set hcnt ← 0. Otherwise increment.
  - sig_o = 0: hcnt ← 0, rph ← 0, no pulses. The edge that clears sig_o suppresses any repeat pulse due at that edge.
- Counter widths are clog2 of the relevant limit. Counters never wrap because they always reset at their threshold.
- Channels are fully independent. Simultaneous events on different channels produce simultaneous pulses.

## Timing
- Reset:
  - s0, s1 and sig_o ← INIT_VALUE; cnt, hcnt, rph ← 0.
  - rise_o, fall_o, press_o ← 0.
  - No edge pulse is generated on reset release.
- Let E0 be the first edge that samples a new stable level into s0. sig_o changes at edge E(CLK_COUNT+1), and rise_o/fall_o are high for the following cycle.
- The first repeat press_o pulse occurs DELAY_CYC cycles after the rise_o cycle. Subsequent pulses occur every PERIOD_CYC cycles.
- If rst is asserted mid-count or mid-repeat, everything returns to the reset state on that edge.

## Test plan
Overrides for all scenarios: CLK_FREQ=1, JITTER_MAX=4 (CLK_COUNT=4), CHANNELS=4, REPEAT_MASK=4'b0001, REPEAT_DELAY=10, REPEAT_PERIOD=3.

- sig_i[0] 0→1, held, sampled at E0 → sig_o[0]=1 after E5; rise_o[0] and press_o[0] high exactly one cycle; other channels unchanged.
- sig_i[1] pulses high 3 cycles, then low → sig_o[1] stays 0; no rise_o or fall_o on channel 1.
- sig_i[0] held high 30 cycles after rise → press_o[0] pulses at rise, rise+10, rise+13, rise+16, …; rise_o only once. Release → fall_o[0] one cycle and repeats stop.
- sig_i[2] held high 30 cycles (mask 0) → single press_o[2] pulse; no repeats.
- rst asserted 2 cycles into a settle count, with INIT_VALUE=4'b1000 and sig_i=4'b1000 → sig_o=4'b1000 and no pulses at any time during or after reset.
- sig_i[0] and sig_i[3] rise on the same edge → rise_o=4'b1001 in the same cycle.
